pulse_detector_marine_radar: RTL and testbench
==============================================

PULSE_DETECTOR_MARINE_RADAR -- requirements
Module: pulse_detector_marine_radar

Interface
REQ-001 SHALL have parameter WIDTH, default 12, sample and threshold width in bits.
REQ-002 SHALL have port clock, input, 1, sole clock (master_clk domain).
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port enable, input, 1, detector run enable.
REQ-005 SHALL have port sig_valid, input, 1, qualifies sig for one cycle.
REQ-006 SHALL have port sig, input, WIDTH, unsigned trigger/ARP/ACP sample.
REQ-007 SHALL have port thresh_excite, input, WIDTH, excitation threshold.
REQ-008 SHALL have port thresh_relax, input, WIDTH, relaxation threshold.
REQ-009 SHALL have port latency, input, 32, consecutive valid samples required to qualify a transition.
REQ-010 SHALL have port pulse, output, 1, one-cycle strobe per detected pulse.
REQ-011 SHALL have port excited, output, 1, high while in EXCITED or DISARMING.
REQ-012 SHALL have port pulse_count, output, 32, pulses detected since reset.
REQ-013 SHALL have port period, output, 32, clock cycles between the last two pulses (macro-gated, see Configuration).

Function
REQ-014 SHALL compare unsigned: sample "high" iff sig >= thresh_excite; "low" iff sig <= thresh_relax; thresholds and latency read live each cycle.
REQ-015 SHALL implement states RELAXED, ARMING, EXCITED, DISARMING, one-hot or encoded.
REQ-016 SHALL, in RELAXED, on valid high sample load qual counter with 1 and enter ARMING.
REQ-017 SHALL, in ARMING, on valid high sample increment qual counter; on valid non-high sample clear counter and return to RELAXED; invalid cycles hold state and counter.
REQ-018 SHALL treat effective latency as max(latency,1); when qual count reaches it, enter EXCITED and assert pulse the following cycle (latency 1: pulse one cycle after the first valid high sample).
REQ-019 SHALL mirror REQ-016..018 for EXCITED->DISARMING->RELAXED on low samples, with no pulse emitted on relaxation.
REQ-020 SHALL handle a sample that is both high and low (thresh_relax >= thresh_excite) per the current state's qualifying test only.
REQ-021 SHALL saturate the qual counter at 0xFFFFFFFF.
REQ-022 SHALL increment pulse_count in the cycle pulse is asserted, wrapping 0xFFFFFFFF->0.
REQ-023 SHALL, while enable low, force RELAXED, clear qual counter, keep pulse low, hold pulse_count and period.
REQ-024 SHALL, on enable deassert in the cycle pulse would assert, suppress the pulse and the count increment.

Reset
REQ-025 SHALL on reset set state RELAXED, qual counter 0, pulse 0, excited 0, pulse_count 0, period 0, period timer 0.
REQ-026 SHALL give reset priority over enable and sig_valid; reset mid-qualification discards the partial count.

Configuration
REQ-027 SHALL compile period measurement only when PULSE_DET_PERIOD_EN is defined.
REQ-028 SHALL, with PULSE_DET_PERIOD_EN, run a 32-bit timer counting every enabled clock, saturating at 0xFFFFFFFF; on each pulse load period with timer+1 and clear the timer; period stays 0 until the second pulse after reset.
REQ-029 SHALL, without PULSE_DET_PERIOD_EN, drive period constant 0 and instantiate no timer logic.

Structure
REQ-030 SHALL place the state encoding and the 32-bit counter width constant in a shared marine-radar package include.
REQ-031 SHALL factor one sub-module, hyst_qual_counter (qual counter with load/increment/clear/saturate and reach compare), instantiated once and shared by ARMING and DISARMING.
REQ-032 SHALL be instantiable three times (trigger, ARP, ACP) fed by the corresponding master-control threshold and latency outputs.

Verification
REQ-033 SHALL test excite=2000, relax=1000, latency=3, sig 0->2500 valid every cycle -> single pulse 3 cycles after the first high sample is registered, pulse_count=1, excited=1.
REQ-034 SHALL test latency=3, sig high for 2 valid samples then 500 -> no pulse, state RELAXED, pulse_count=0.
REQ-035 SHALL test latency=0 vs latency=1 with same stimulus -> identical pulse timing.
REQ-036 SHALL test sig_valid toggling every other cycle with latency=4 -> pulse after 4th valid high sample, invalid cycles ignored.
REQ-037 SHALL test macro defined, pulses 100 clocks apart -> period=100 after second pulse; macro undefined -> period=0.
REQ-038 SHALL test reset asserted during ARMING with count 2 -> outputs at reset values next cycle, requalification restarts from 1.

Source files
------------

// File: rtl/pulse_detector_marine_radar_pkg.sv
// Shared marine-radar definitions: detector state encoding, counter width and
// the effective-latency helper used by the pulse detector.
package pulse_detector_marine_radar_pkg;

  localparam int unsigned CNT_W = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

  typedef enum logic [1:0] {
    RELAXED   = 2'd0,
    ARMING    = 2'd1,
    EXCITED   = 2'd2,
    DISARMING = 2'd3
  } det_state_t;

  // A latency of zero behaves exactly like a latency of one.
  function automatic cnt_t eff_latency(input cnt_t lat);
    return (lat == '0) ? cnt_t'(1) : lat;
  endfunction

endpackage

// File: rtl/pulse_detector_marine_radar_hyst_qual_counter.sv
// Qualification counter shared by the ARMING and DISARMING phases:
// clear > load-with-1 > saturating increment, plus a reach compare.
module hyst_qual_counter
  import pulse_detector_marine_radar_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_inc,
  input  logic i_clr,
  input  cnt_t i_limit,
  output logic o_reach
);

  cnt_t r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= cnt_t'(1);
    end else if (i_inc && (r_count != CNT_MAX)) begin
      r_count <= r_count + cnt_t'(1);
    end
  end

  assign o_reach = (r_count >= i_limit);

endmodule

// File: rtl/pulse_detector_marine_radar.sv
// Hysteretic pulse detector for trigger/ARP/ACP inputs.
// Period measurement is compiled only when PULSE_DET_PERIOD_EN is defined.
module pulse_detector_marine_radar
  import pulse_detector_marine_radar_pkg::*;
#(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_valid,
  input  logic [WIDTH-1:0] sig,
  input  logic [WIDTH-1:0] thresh_excite,
  input  logic [WIDTH-1:0] thresh_relax,
  input  logic [CNT_W-1:0] latency,
  output logic             pulse,
  output logic             excited,
  output logic [CNT_W-1:0] pulse_count,
  output logic [CNT_W-1:0] period
);

  det_state_t r_state;
  logic       r_pulse;
  cnt_t       r_pulse_count;

  logic w_high, w_low;
  logic w_load, w_inc, w_clr;
  logic w_reach, w_fire, w_relax_done;
  cnt_t w_limit;

  assign w_high  = (sig >= thresh_excite);
  assign w_low   = (sig <= thresh_relax);
  assign w_limit = eff_latency(latency);

  // The transition is taken on the edge after the qualifying count is
  // registered; that edge ignores the sample presented with it.
  always_comb begin
    w_load = 1'b0;
    w_inc  = 1'b0;
    w_clr  = 1'b0;
    if (!enable) begin
      w_clr = 1'b1;
    end else begin
      case (r_state)
        RELAXED: w_load = sig_valid && w_high;
        ARMING: begin
          if (w_reach) w_clr = 1'b1;
          else if (sig_valid) begin
            w_inc = w_high;
            w_clr = !w_high;
          end
        end
        EXCITED: w_load = sig_valid && w_low;
        DISARMING: begin
          if (w_reach) w_clr = 1'b1;
          else if (sig_valid) begin
            w_inc = w_low;
            w_clr = !w_low;
          end
        end
        default: w_clr = 1'b1;
      endcase
    end
  end

  assign w_fire       = enable && (r_state == ARMING) && w_reach;
  assign w_relax_done = enable && (r_state == DISARMING) && w_reach;

  hyst_qual_counter u_qual (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_load  (w_load),
    .i_inc   (w_inc),
    .i_clr   (w_clr),
    .i_limit (w_limit),
    .o_reach (w_reach)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= RELAXED;
      r_pulse       <= 1'b0;
      r_pulse_count <= '0;
    end else begin
      r_pulse <= w_fire;
      if (w_fire) r_pulse_count <= r_pulse_count + cnt_t'(1);
      if (!enable) begin
        r_state <= RELAXED;
      end else begin
        case (r_state)
          RELAXED:   if (sig_valid && w_high) r_state <= ARMING;
          ARMING: begin
            if (w_fire) r_state <= EXCITED;
            else if (sig_valid && !w_high) r_state <= RELAXED;
          end
          EXCITED:   if (sig_valid && w_low) r_state <= DISARMING;
          DISARMING: begin
            if (w_relax_done) r_state <= RELAXED;
            else if (sig_valid && !w_low) r_state <= EXCITED;
          end
          default:   r_state <= RELAXED;
        endcase
      end
    end
  end

  assign pulse       = r_pulse;
  assign excited     = (r_state == EXCITED) || (r_state == DISARMING);
  assign pulse_count = r_pulse_count;

`ifdef PULSE_DET_PERIOD_EN
  cnt_t r_timer;
  cnt_t r_period;
  logic r_seen;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_timer  <= '0;
      r_period <= '0;
      r_seen   <= 1'b0;
    end else if (enable) begin
      if (w_fire) begin
        r_timer <= '0;
        r_seen  <= 1'b1;
        if (r_seen) r_period <= (r_timer == CNT_MAX) ? CNT_MAX : r_timer + cnt_t'(1);
      end else if (r_timer != CNT_MAX) begin
        r_timer <= r_timer + cnt_t'(1);
      end
    end
  end

  assign period = r_period;
`else
  assign period = '0;
`endif

endmodule

// File: tb/tb_pulse_detector_marine_radar.sv
// Self-checking bench for pulse_detector_marine_radar: directed scenarios plus
// randomized traffic against a two-phase behavioural model.
module tb_pulse_detector_marine_radar;

  logic        clock = 1'b0;
  logic        reset, enable, sig_valid;
  logic [11:0] sig, thresh_excite, thresh_relax;
  logic [31:0] latency;
  logic        pulse, excited;
  logic [31:0] pulse_count, period;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

`ifdef PULSE_DET_PERIOD_EN
  localparam bit PERIOD_EN = 1'b1;
`else
  localparam bit PERIOD_EN = 1'b0;
`endif

  always #5 clock = ~clock;

  pulse_detector_marine_radar #(.WIDTH(12)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .sig_valid     (sig_valid),
    .sig           (sig),
    .thresh_excite (thresh_excite),
    .thresh_relax  (thresh_relax),
    .latency       (latency),
    .pulse         (pulse),
    .excited       (excited),
    .pulse_count   (pulse_count),
    .period        (period)
  );

  // Model: a polarity (excited or not) and a run of consecutive qualifying
  // valid samples; once the run reaches the latency the next edge flips polarity.
  bit          m_exc, m_pulse, m_seen;
  int unsigned m_run;
  logic [31:0] m_cnt, m_period, m_stamp, m_last;

  task automatic model_step();
    int unsigned lim;
    bit qual;
    lim = (latency == 0) ? 1 : latency;
    m_pulse = 1'b0;
    if (reset) begin
      m_exc = 0; m_run = 0; m_cnt = 0; m_period = 0;
      m_stamp = 0; m_last = 0; m_seen = 0;
    end else if (!enable) begin
      m_exc = 0; m_run = 0;
    end else begin
      m_stamp = m_stamp + 1;
      if (m_run >= lim) begin
        m_run = 0;
        m_exc = !m_exc;
        if (m_exc) begin
          m_pulse = 1'b1;
          m_cnt   = m_cnt + 1;
          if (PERIOD_EN && m_seen) m_period = m_stamp - m_last;
          m_last = m_stamp;
          m_seen = 1'b1;
        end
      end else if (sig_valid) begin
        qual  = m_exc ? (sig <= thresh_relax) : (sig >= thresh_excite);
        m_run = !qual ? 0 : (m_run == 32'hFFFF_FFFF) ? m_run : m_run + 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    n_checks++;
    if (pulse !== m_pulse) begin
      n_fail++; $display("FAIL model_pulse t=%0t got %b expected %b", $time, pulse, m_pulse);
    end
    n_checks++;
    if (excited !== m_exc) begin
      n_fail++; $display("FAIL model_excited t=%0t got %b expected %b", $time, excited, m_exc);
    end
    n_checks++;
    if (pulse_count !== m_cnt) begin
      n_fail++; $display("FAIL model_count t=%0t got %0d expected %0d", $time, pulse_count, m_cnt);
    end
    n_checks++;
    if (period !== m_period) begin
      n_fail++; $display("FAIL model_period t=%0t got %0d expected %0d", $time, period, m_period);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; sig_valid = 1'b1; sig = '0;
    tick();
    reset = 1'b0;
  endtask

  // Runs n ticks with current inputs; reports first pulse index and pulse total.
  task automatic run_watch(input int n, output int first, output int np);
    first = -1; np = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (pulse === 1'b1) begin
        if (first < 0) first = i;
        np++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; sig_valid = 1'b1; sig = 12'd4000;
    thresh_excite = 12'd2000; thresh_relax = 12'd1000; latency = 32'd1;
    tick(); tick();
    n_checks++;
    if (pulse !== 1'b0 || excited !== 1'b0 || pulse_count !== 32'd0 || period !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_values got p=%b e=%b c=%0d per=%0d expected 0 0 0 0", pulse, excited, pulse_count, period);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int first, np;
    do_reset();
    thresh_excite = 12'd2000; thresh_relax = 12'd1000; latency = 32'd3;
    sig = 12'd0;
    repeat (3) tick();
    sig = 12'd2500;
    run_watch(10, first, np);
    n_checks++;
    if (first != 3 || np != 1) begin
      n_fail++; $display("FAIL basic_timing got first=%0d n=%0d expected first=3 n=1", first, np);
    end
    n_checks++;
    if (pulse_count !== 32'd1 || excited !== 1'b1) begin
      n_fail++; $display("FAIL basic_state got count=%0d exc=%b expected 1 1", pulse_count, excited);
    end
  endtask

  task automatic test_abort();
    int first, np;
    do_reset();
    latency = 32'd3;
    sig = 12'd2500; repeat (2) tick();
    sig = 12'd500;
    run_watch(6, first, np);
    n_checks++;
    if (np != 0 || excited !== 1'b0 || pulse_count !== 32'd0) begin
      n_fail++; $display("FAIL abort got n=%0d exc=%b count=%0d expected 0 0 0", np, excited, pulse_count);
    end
    sig = 12'd2500;
    run_watch(8, first, np);
    n_checks++;
    if (first != 3) begin
      n_fail++; $display("FAIL abort_requal got first=%0d expected 3", first);
    end
  endtask

  task automatic test_latency01();
    int first[2];
    int np;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      latency = k;
      sig = 12'd0; tick();
      sig = 12'd2500;
      run_watch(6, first[k], np);
    end
    n_checks++;
    if (first[0] != 1 || first[1] != 1) begin
      n_fail++; $display("FAIL latency01 got lat0=%0d lat1=%0d expected 1 1", first[0], first[1]);
    end
  endtask

  task automatic test_valid_toggle();
    int first;
    first = -1;
    do_reset();
    latency = 32'd4;
    for (int i = 0; i < 16; i++) begin
      sig_valid = (i % 2 == 0);
      sig = sig_valid ? 12'd2500 : 12'd0;
      tick();
      if (pulse === 1'b1 && first < 0) first = i;
    end
    sig_valid = 1'b1;
    n_checks++;
    if (first != 7) begin
      n_fail++; $display("FAIL valid_toggle got first=%0d expected 7", first);
    end
  endtask

  task automatic test_period();
    int idx[$];
    logic [31:0] mid_period;
    do_reset();
    latency = 32'd1;
    mid_period = 32'hDEAD;
    for (int c = 0; c < 120; c++) begin
      sig = (c == 0 || c == 100) ? 12'd2500 : 12'd0;
      tick();
      if (pulse === 1'b1) idx.push_back(c);
      if (c == 50) mid_period = period;
    end
    n_checks++;
    if (idx.size() != 2 || idx[0] != 1 || idx[1] != 101) begin
      n_fail++; $display("FAIL period_pulses got n=%0d expected pulses at 1 and 101", idx.size());
    end
    n_checks++;
    if (mid_period !== 32'd0) begin
      n_fail++; $display("FAIL period_first got %0d expected 0", mid_period);
    end
    n_checks++;
    if (period !== (PERIOD_EN ? 32'd100 : 32'd0)) begin
      n_fail++; $display("FAIL period_value got %0d expected %0d", period, PERIOD_EN ? 100 : 0);
    end
  endtask

  task automatic test_reset_mid();
    int first, np;
    do_reset();
    latency = 32'd1;
    sig = 12'd2500; repeat (3) tick();
    sig = 12'd0;    repeat (3) tick();
    latency = 32'd5;
    sig = 12'd2500; repeat (2) tick();
    reset = 1'b1; tick();
    n_checks++;
    if (pulse !== 1'b0 || excited !== 1'b0 || pulse_count !== 32'd0 || period !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid got p=%b e=%b c=%0d per=%0d expected 0 0 0 0", pulse, excited, pulse_count, period);
    end
    reset = 1'b0;
    run_watch(10, first, np);
    n_checks++;
    if (first != 5) begin
      n_fail++; $display("FAIL reset_mid_requal got first=%0d expected 5", first);
    end
  endtask

  task automatic test_enable_suppress();
    int first, np;
    do_reset();
    latency = 32'd2;
    sig = 12'd2500; repeat (2) tick();
    enable = 1'b0; tick();
    n_checks++;
    if (pulse !== 1'b0 || pulse_count !== 32'd0 || excited !== 1'b0) begin
      n_fail++; $display("FAIL enable_suppress got p=%b c=%0d e=%b expected 0 0 0", pulse, pulse_count, excited);
    end
    enable = 1'b1;
    run_watch(6, first, np);
    n_checks++;
    if (first != 2 || pulse_count !== 32'd1) begin
      n_fail++; $display("FAIL enable_resume got first=%0d count=%0d expected 2 1", first, pulse_count);
    end
  endtask

  task automatic test_random();
    int unsigned start_cnt;
    do_reset();
    start_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        thresh_excite = 12'($urandom_range(1500, 3000));
        thresh_relax  = 12'($urandom_range(500, int'(thresh_excite) + 200));
        latency       = $urandom_range(0, 4);
      end
      sig_valid = ($urandom_range(0, 3) != 0);
      sig       = 12'($urandom_range(0, 4095));
      enable    = ($urandom_range(0, 63) != 0);
      reset     = ($urandom_range(0, 499) == 0);
      tick();
      if (pulse === 1'b1) start_cnt++;
    end
    reset = 1'b0; enable = 1'b1;
    n_checks++;
    if (start_cnt == 0) begin
      n_fail++; $display("FAIL random_activity got 0 pulses expected some");
    end
  endtask

  initial begin
    m_exc = 0; m_run = 0; m_cnt = 0; m_period = 0; m_stamp = 0; m_last = 0; m_seen = 0; m_pulse = 0;
    test_reset();
    test_basic();
    test_abort();
    test_latency01();
    test_valid_toggle();
    test_period();
    test_reset_mid();
    test_enable_suppress();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
